spi_frame_deserializer: RTL and testbench

//  System-clock-domain SPI receiver for the MCU-to-FPGA link. Oversamples sclk/sdi/cs_n,

---
 rtl/physics_spi_pkg.sv | 18 +
 rtl/frame_fifo.sv | 80 ++++++++
 rtl/spi_frame_deserializer.sv | 132 +++++++++++++
 tb/tb_spi_frame_deserializer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/physics_spi_pkg.sv
// Shared frame geometry and receiver state encoding for the MCU-to-FPGA SPI link.
package physics_spi_pkg;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 3;
  localparam int FRAME_W   = WORD_W * NUM_WORDS;
  localparam int BITCNT_W  = $clog2(FRAME_W + 1);

  typedef logic signed [WORD_W-1:0] word_t;
  typedef logic [FRAME_W-1:0]       frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } spi_rx_state_t;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame FIFO whose head entry is held in a register, so rd_valid/rd_data
// change only on clock edges and the next entry is visible the cycle after a pop.
module frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             pop_ok;
  logic             push_ok;
  logic             head_from_push;

  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && rd_valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);

  // The new head is the word being written when nothing older survives this cycle.
  assign head_from_push = push_ok &&
                          ((count == '0) || ((count == CNT_W'(1)) && pop_ok));

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (pop_ok) begin
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      if (head_from_push) begin
        rd_data <= wr_data;
      end else if (count_nxt != '0) begin
        rd_data <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/spi_frame_deserializer.sv
// Oversampling SPI mode-0 receiver: synchronises sclk/sdi/cs_n into clk, assembles
// 48-bit {x,y,z} frames and queues them for the physics core via valid/ready.
module spi_frame_deserializer
  import physics_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               sdi,
  input  logic               cs_n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_data,
  output logic               frame_err,
  output logic               overflow
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RECV = 2'(RECV);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] cs_n_sync;
  logic                   sclk_prev;
  logic                   cs_n_prev;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   cs_n_s;
  logic                   sclk_rise;
  logic                   cs_fall;

  logic [1:0]             state;
  logic [BITCNT_W-1:0]    bit_cnt;
  frame_t                 shift;
  logic                   push_req;
  logic                   fifo_full;
  logic                   pop;

  // sdi is taken from the same stage as sclk so the sampled bit matches the detected edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_n_sync <= '0;
      sclk_prev <= 1'b0;
      cs_n_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_n_prev <= cs_n_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s && !sclk_prev;
  // cs_n_prev clears on reset, so a cs_n held low through reset never looks like a new frame.
  assign cs_fall   = cs_n_prev && !cs_n_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_RECV;
            bit_cnt <= '0;
            shift   <= '0;
          end
        end
        ST_RECV: begin
          if (cs_n_s) begin
            frame_err <= (bit_cnt != '0);
            state     <= ST_IDLE;
          end else if (sclk_rise) begin
            shift   <= {shift[FRAME_W-2:0], sdi_s};
            bit_cnt <= bit_cnt + BITCNT_W'(1);
            if (bit_cnt == BITCNT_W'(FRAME_W - 1)) begin
              push_req <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cs_n_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .wr_data  (shift),
    .pop      (pop),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_spi_frame_deserializer.sv
// Self-checking bench for spi_frame_deserializer: directed SPI scenarios plus random
// batches, compared against a queue model of delivered frames, errors and overflow.
module tb_spi_frame_deserializer;
  import physics_spi_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk;
  logic         sdi;
  logic         cs_n;
  logic         out_valid;
  logic         out_ready;
  logic [47:0]  out_data;
  logic         frame_err;
  logic         overflow;

  int     compared   = 0;
  int     mismatched = 0;
  frame_t model_q[$];
  bit     overflow_exp = 1'b0;
  int     err_exp  = 0;
  int     err_seen = 0;
  bit     err_wide = 1'b0;
  logic   err_prev = 1'b0;

  always #5 clk = ~clk;

  spi_frame_deserializer #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sdi       (sdi),
    .cs_n      (cs_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // frame_err pulses are counted and must never last more than one cycle.
  always @(negedge clk) begin
    if (reset) begin
      err_prev = 1'b0;
    end else begin
      if (frame_err) begin
        err_seen++;
        if (err_prev) err_wide = 1'b1;
      end
      err_prev = frame_err;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    sdi = b;
    wait_cycles(4);
    sclk = 1'b1;
    wait_cycles(4);
    sclk = 1'b0;
  endtask

  task automatic model_push(input frame_t f);
    if (model_q.size() >= DEPTH) overflow_exp = 1'b1;
    else model_q.push_back(f);
  endtask

  // One cs_n window carrying nbits bits (first 48 taken from f, MSB first).
  // With pop_at_push the consumer takes one frame in the cycle the 48th bit is pushed.
  task automatic applyStimulus(input frame_t f, input int nbits, input bit pop_at_push);
    logic b;
    cs_n = 1'b0;
    wait_cycles(4);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 48) ? f[47-i] : 1'($urandom);
      if (i == 47 && pop_at_push) begin
        sdi = b;
        wait_cycles(4);
        sclk = 1'b1;
        wait_cycles(3);
        checkOutput("pre_pop_valid", 64'(out_valid), 64'(1));
        if (model_q.size() > 0) begin
          checkOutput("pre_pop_data", 64'(out_data), 64'(model_q[0]));
          void'(model_q.pop_front());
        end
        out_ready = 1'b1;
        wait_cycles(1);
        out_ready = 1'b0;
        sclk = 1'b0;
      end else begin
        spi_bit(b);
      end
      if (i == 47) model_push(f);
    end
    wait_cycles(4);
    cs_n = 1'b1;
    wait_cycles(6);
    if (nbits > 0 && nbits < 48) err_exp++;
    checkOutput("frame_err_count", 64'(err_seen), 64'(err_exp));
    checkOutput("frame_err_width", 64'(err_wide), 64'(0));
    checkOutput("overflow", 64'(overflow), 64'(overflow_exp));
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (!out_valid) break;
      if (model_q.size() == 0) begin
        checkOutput("spurious_valid", 64'(out_valid), 64'(0));
        break;
      end
      checkOutput("drain_data", 64'(out_data), 64'(model_q.pop_front()));
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("drain_left", 64'(model_q.size()), 64'(0));
    wait_cycles(2);
    checkOutput("valid_after_drain", 64'(out_valid), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cycles(3);
    checkOutput("reset_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_overflow", 64'(overflow), 64'(0));
    reset = 1'b0;
    model_q.delete();
    overflow_exp = 1'b0;
    wait_cycles(3);
  endtask

  frame_t f;
  word_t  w;
  int     nb;
  int     r;

  initial begin
    reset     = 1'b1;
    sclk      = 1'b0;
    sdi       = 1'b0;
    cs_n      = 1'b1;
    out_ready = 1'b0;
    wait_cycles(3);
    checkOutput("reset_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_data", 64'(out_data), 64'(0));
    checkOutput("reset_frame_err", 64'(frame_err), 64'(0));
    checkOutput("reset_overflow", 64'(overflow), 64'(0));
    reset = 1'b0;
    wait_cycles(4);

    $display("[TB] signed word frame");
    applyStimulus(48'h0001_FFFF_8000, 48, 1'b0);
    checkOutput("t1_valid", 64'(out_valid), 64'(1));
    checkOutput("t1_data", 64'(out_data), 64'h0001FFFF8000);
    w = out_data[47:32];
    checkOutput("t1_word0", 64'(int'(w)), 64'(1));
    w = out_data[31:16];
    checkOutput("t1_word1", 64'(int'(w)), {64{1'b1}});
    w = out_data[15:0];
    checkOutput("t1_word2", 64'(int'(w)), 64'(-32768));
    drain();

    $display("[TB] short frame then good frame");
    applyStimulus(48'($urandom) << 16, 20, 1'b0);
    checkOutput("t2_no_valid", 64'(out_valid), 64'(0));
    applyStimulus(48'h1234_5678_9ABC, 48, 1'b0);
    drain();

    $display("[TB] overflow with consumer stalled");
    for (int k = 1; k <= 5; k++) begin
      applyStimulus({16'($urandom), 16'($urandom), 16'(k)}, 48, 1'b0);
    end
    checkOutput("t3_overflow", 64'(overflow), 64'(1));
    drain();

    $display("[TB] full fifo with pop on push cycle");
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus({16'($urandom), 16'($urandom), 16'(k)}, 48, 1'b0);
    end
    applyStimulus({16'($urandom), 16'($urandom), 16'(5)}, 48, 1'b1);
    checkOutput("t4_overflow", 64'(overflow), 64'(0));
    drain();

    $display("[TB] long cs window");
    applyStimulus({$urandom, 16'($urandom)}, 60, 1'b0);
    drain();

    $display("[TB] reset mid-frame");
    cs_n = 1'b0;
    wait_cycles(4);
    for (int i = 0; i < 30; i++) spi_bit(1'($urandom));
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    model_q.delete();
    overflow_exp = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < 18; i++) spi_bit(1'($urandom));
    wait_cycles(4);
    cs_n = 1'b1;
    wait_cycles(6);
    checkOutput("t6_no_valid", 64'(out_valid), 64'(0));
    checkOutput("t6_no_err", 64'(err_seen), 64'(err_exp));
    checkOutput("t6_overflow", 64'(overflow), 64'(0));
    applyStimulus(48'hAAAA_5555_0F0F, 48, 1'b0);
    drain();

    $display("[TB] random batches");
    for (int bt = 0; bt < 10; bt++) begin
      for (int n = $urandom_range(1, 6); n > 0; n--) begin
        r = $urandom_range(0, 9);
        if (r < 7) nb = 48;
        else if (r < 8) nb = $urandom_range(49, 64);
        else nb = $urandom_range(1, 47);
        f = {$urandom, 16'($urandom)};
        applyStimulus(f, nb, 1'b0);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
